// File: rtl/opsg_pkg.sv
// rtl/opsg_pkg.sv - shared strobe state, lock owner and PSG byte constants for the write arbiter
package opsg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_GAP    = 2'd3
    } strobe_state_e;

    typedef enum logic [1:0] {
        LK_NONE = 2'd0,
        LK_A    = 2'd1,
        LK_B    = 2'd2
    } lock_owner_e;

    localparam logic [7:0] PSG_IDLE_DATA = 8'hFF;

    // Attenuation-off commands for tone 0..2 and noise.
    localparam logic [7:0] MUTE_CH0   = 8'h9F;
    localparam logic [7:0] MUTE_CH1   = 8'hBF;
    localparam logic [7:0] MUTE_CH2   = 8'hDF;
    localparam logic [7:0] MUTE_NOISE = 8'hFF;
    localparam int         MUTE_LEN   = 4;

    function automatic logic [7:0] mute_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    mute_byte = MUTE_CH0;
            2'd1:    mute_byte = MUTE_CH1;
            2'd2:    mute_byte = MUTE_CH2;
            default: mute_byte = MUTE_NOISE;
        endcase
    endfunction

endpackage

// File: rtl/psg_wr_arbiter_if.sv
// rtl/psg_wr_arbiter_if.sv - requester handshakes and PSG bus of the write arbiter
interface psg_wr_arbiter_if;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_lock;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_lock;
    logic       b_ready;
    logic       mute_req;
    logic       mute_busy;
    logic       psg_n_wr;
    logic [7:0] psg_data;
    logic       busy;
    logic       lock_err;

    modport master (
        output a_valid, a_data, a_lock, b_valid, b_data, b_lock, mute_req,
        input  a_ready, b_ready, mute_busy, psg_n_wr, psg_data, busy, lock_err
    );

    modport slave (
        input  a_valid, a_data, a_lock, b_valid, b_data, b_lock, mute_req,
        output a_ready, b_ready, mute_busy, psg_n_wr, psg_data, busy, lock_err
    );
endinterface

// File: rtl/psg_wr_strobe.sv
// rtl/psg_wr_strobe.sv - per-byte write strobe timing: STROBE low, HOLD, then idle-data GAP
module psg_wr_strobe
    import opsg_pkg::*;
#(
    parameter int WR_LOW_CYCLES = 2,
    parameter int WR_GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       idle_o,
    output logic       psg_n_wr_o,
    output logic [7:0] psg_data_o
);
    localparam int MAXC = (WR_LOW_CYCLES > WR_GAP_CYCLES) ? WR_LOW_CYCLES : WR_GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    strobe_state_e   state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      byte_q, byte_d;
    logic            n_wr_q, n_wr_d;
    logic [7:0]      data_q, data_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_STROBE;
                    cnt_d   = CW'(WR_LOW_CYCLES - 1);
                    byte_d  = byte_i;
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) state_d = ST_HOLD;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_HOLD: begin
                state_d = ST_GAP;
                cnt_d   = CW'(WR_GAP_CYCLES - 1);
            end
            ST_GAP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        // Bus pins follow the next state so they change on the same edge as the FSM.
        n_wr_d = (state_d != ST_STROBE);
        data_d = (state_d == ST_STROBE || state_d == ST_HOLD) ? byte_d : PSG_IDLE_DATA;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            byte_q  <= PSG_IDLE_DATA;
            n_wr_q  <= 1'b1;
            data_q  <= PSG_IDLE_DATA;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            n_wr_q  <= n_wr_d;
            data_q  <= data_d;
        end
    end

    assign idle_o     = (state_q == ST_IDLE);
    assign psg_n_wr_o = n_wr_q;
    assign psg_data_o = data_q;
endmodule

// File: rtl/psg_wr_arbiter.sv
// rtl/psg_wr_arbiter.sv - two-port PSG write arbiter with lock/timeout; mute sequencer under PSG_ARB_MUTE_EN
module psg_wr_arbiter
    import opsg_pkg::*;
#(
    parameter int WR_LOW_CYCLES = 2,
    parameter int WR_GAP_CYCLES = 2,
    parameter int LOCK_TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                rst,
    psg_wr_arbiter_if.slave     bus
);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    logic          st_idle;
    logic          start;
    logic [7:0]    start_byte;
    logic          mute_go;
    logic          mute_take;
    logic [7:0]    mute_data;
    logic          grant_a, grant_b, can_take, a_acc, b_acc, holder_valid;

    lock_owner_e   lock_q, lock_d;
    logic          prefer_b_q, prefer_b_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          lock_err_q, lock_err_d;

    psg_wr_strobe #(
        .WR_LOW_CYCLES (WR_LOW_CYCLES),
        .WR_GAP_CYCLES (WR_GAP_CYCLES)
    ) u_strobe (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .byte_i     (start_byte),
        .idle_o     (st_idle),
        .psg_n_wr_o (bus.psg_n_wr),
        .psg_data_o (bus.psg_data)
    );

`ifdef PSG_ARB_MUTE_EN
    logic       mute_pend_q, mute_pend_d;
    logic [2:0] mute_cnt_q, mute_cnt_d;
    logic       mute_done;
    logic       mute_busy;

    // mute_cnt counts bytes issued; the sequence ends once the last byte's GAP is over.
    always_comb begin
        mute_done   = mute_pend_q && (mute_cnt_q == 3'(MUTE_LEN)) && st_idle;
        mute_busy   = mute_pend_q && !mute_done;
        mute_go     = mute_pend_q && (mute_cnt_q != 3'(MUTE_LEN)) && (lock_q == LK_NONE);
        mute_take   = mute_go && st_idle && !rst;
        mute_data   = mute_byte(mute_cnt_q[1:0]);
        mute_pend_d = mute_pend_q;
        mute_cnt_d  = mute_cnt_q;
        if (mute_done) begin
            mute_pend_d = 1'b0;
            mute_cnt_d  = '0;
        end
        if (mute_take) mute_cnt_d = mute_cnt_q + 3'd1;
        if (bus.mute_req && !mute_busy) begin
            mute_pend_d = 1'b1;
            mute_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mute_pend_q <= 1'b0;
            mute_cnt_q  <= '0;
        end else begin
            mute_pend_q <= mute_pend_d;
            mute_cnt_q  <= mute_cnt_d;
        end
    end

    assign bus.mute_busy = mute_busy;
`else
    logic unused_mute_req;
    assign unused_mute_req = bus.mute_req;
    assign mute_go         = 1'b0;
    assign mute_take       = 1'b0;
    assign mute_data       = PSG_IDLE_DATA;
    assign bus.mute_busy   = 1'b0;
`endif

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (lock_q)
            LK_A: grant_a = 1'b1;
            LK_B: grant_b = 1'b1;
            default: begin
                if (bus.a_valid && bus.b_valid) begin
                    grant_a = !prefer_b_q;
                    grant_b = prefer_b_q;
                end else begin
                    grant_a = bus.a_valid;
                    grant_b = bus.b_valid;
                end
            end
        endcase

        can_take     = st_idle && !rst && !mute_go;
        a_acc        = can_take && grant_a && bus.a_valid;
        b_acc        = can_take && grant_b && bus.b_valid;
        start        = a_acc || b_acc || mute_take;
        start_byte   = mute_take ? mute_data : (a_acc ? bus.a_data : bus.b_data);
        holder_valid = (lock_q == LK_A) ? bus.a_valid : bus.b_valid;

        lock_d     = lock_q;
        prefer_b_d = prefer_b_q;
        to_cnt_d   = to_cnt_q;
        lock_err_d = 1'b0;
        if (a_acc) begin
            lock_d     = bus.a_lock ? LK_A : LK_NONE;
            prefer_b_d = 1'b1;
            to_cnt_d   = '0;
        end else if (b_acc) begin
            lock_d     = bus.b_lock ? LK_B : LK_NONE;
            prefer_b_d = 1'b0;
            to_cnt_d   = '0;
        end else if (st_idle && (lock_q != LK_NONE) && !holder_valid) begin
            // A holder that stays silent too long loses the lock so the other side cannot starve.
            if (to_cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
                lock_d     = LK_NONE;
                to_cnt_d   = '0;
                lock_err_d = 1'b1;
            end else begin
                to_cnt_d   = to_cnt_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q     <= LK_NONE;
            prefer_b_q <= 1'b0;
            to_cnt_q   <= '0;
            lock_err_q <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            prefer_b_q <= prefer_b_d;
            to_cnt_q   <= to_cnt_d;
            lock_err_q <= lock_err_d;
        end
    end

    assign bus.a_ready  = a_acc;
    assign bus.b_ready  = b_acc;
    assign bus.busy     = !st_idle;
    assign bus.lock_err = lock_err_q;
endmodule
